// File: rtl/half_adder_rr_sched.sv
// half_adder_rr_sched: round-robin share of one registered half adder among N requesters, id-tagged responses.
// Optional HA_SCHED_STATS_EN adds per-requester saturating grant counters on grant_cnt.
module half_adder_rr_sched #(
    parameter int N   = 4,
    parameter int IDW = 2,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   gnt,
    output logic           ha_a,
    output logic           ha_b,
    input  logic           ha_sum,
    input  logic           ha_carry,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic           rsp_sum,
    output logic           rsp_carry
`ifdef HA_SCHED_STATS_EN
    ,output logic [16*N-1:0] grant_cnt
`endif
);
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, win;
    logic           found, take;
    logic [LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0] tag_id_q [LAT];
    logic [IDW-1:0] tag_id_d [LAT];
    logic           rsp_valid_q, rsp_valid_d, rsp_sum_q, rsp_sum_d, rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    always_comb begin
        found = 1'b0;
        win   = '0;
        // first pass covers rr_ptr..N-1, second pass wraps to 0..rr_ptr-1
        for (int i = 0; i < N; i++)
            if (!found && req[i] && i >= int'(rr_ptr_q)) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        for (int i = 0; i < N; i++)
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        take     = found & rstn;
        gnt      = take ? N'(1) << win : '0;
        ha_a     = take & a[win];
        ha_b     = take & b[win];
        rr_ptr_d = take ? ((win == IDW'(N-1)) ? '0 : win + 1'b1) : rr_ptr_q;
        tag_v_d[0]  = take;
        tag_id_d[0] = win;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
        rsp_valid_d = tag_v_q[LAT-1];
        rsp_id_d    = tag_v_q[LAT-1] ? tag_id_q[LAT-1] : rsp_id_q;
        rsp_sum_d   = tag_v_q[LAT-1] ? ha_sum : rsp_sum_q;
        rsp_carry_d = tag_v_q[LAT-1] ? ha_carry : rsp_carry_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q    <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= 1'b0;
            rsp_carry_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
`ifdef HA_SCHED_STATS_EN
    logic [15:0] cnt_q [N];
    logic [15:0] cnt_d [N];
    always_comb begin
        for (int k = 0; k < N; k++)
            cnt_d[k] = (take && win == IDW'(k) && cnt_q[k] != 16'hFFFF) ? cnt_q[k] + 16'd1 : cnt_q[k];
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '{default: '0};
        else
            cnt_q <= cnt_d;
    end
    for (genvar k = 0; k < N; k++) begin : g_cnt
        assign grant_cnt[16*k +: 16] = cnt_q[k];
    end
`endif
endmodule

// File: tb/tb_half_adder_rr_sched.sv
// tb_half_adder_rr_sched: directed vector table for the LAT=1 scheduler plus reset-mid-flight on a LAT=3 copy.
module tb_half_adder_rr_sched;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;
    logic [3:0] req = '0, a = '0, b = '0, gnt;
    logic ha_a, ha_b, ha_sum = 1'b0, ha_carry = 1'b0, rsp_valid, rsp_sum, rsp_carry;
    logic [1:0] rsp_id;
    logic [3:0] req3 = '0, a3 = '0, b3 = '0, gnt3;
    logic ha_a3, ha_b3, rsp_valid3, rsp_sum3, rsp_carry3;
    logic [1:0] rsp_id3;
    logic [2:0] s3 = '0, c3 = '0;
`ifdef HA_SCHED_STATS_EN
    logic [63:0] grant_cnt, grant_cnt3;
`endif
    int errors = 0, checks = 0;

    half_adder_rr_sched #(.N(4), .IDW(2), .LAT(1)) u1 (
        .clk(clk), .rstn(rstn), .req(req), .a(a), .b(b), .gnt(gnt),
        .ha_a(ha_a), .ha_b(ha_b), .ha_sum(ha_sum), .ha_carry(ha_carry),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef HA_SCHED_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );
    half_adder_rr_sched #(.N(4), .IDW(2), .LAT(3)) u3 (
        .clk(clk), .rstn(rstn), .req(req3), .a(a3), .b(b3), .gnt(gnt3),
        .ha_a(ha_a3), .ha_b(ha_b3), .ha_sum(s3[2]), .ha_carry(c3[2]),
        .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .rsp_carry(rsp_carry3)
`ifdef HA_SCHED_STATS_EN
        , .grant_cnt(grant_cnt3)
`endif
    );

    // registered half adders: latency 1 and latency 3
    always_ff @(posedge clk) begin
        ha_sum   <= ha_a ^ ha_b;
        ha_carry <= ha_a & ha_b;
        s3       <= {s3[1:0], ha_a3 ^ ha_b3};
        c3       <= {c3[1:0], ha_a3 & ha_b3};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0] req, a, b, gnt;
        logic       v;
        logic [1:0] id;
        logic       s, c;
    } vec_t;
    vec_t tbl [14];

    initial begin
        tbl[0]  = {4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[2]  = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b1};
        tbl[3]  = {4'b1111, 4'b1010, 4'b0110, 4'b1000, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[4]  = {4'b1111, 4'b1010, 4'b0110, 4'b0001, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[5]  = {4'b1111, 4'b1010, 4'b0110, 4'b0010, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[6]  = {4'b1111, 4'b1010, 4'b0110, 4'b0100, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[7]  = {4'b1111, 4'b1010, 4'b0110, 4'b1000, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[8]  = {4'b1010, 4'b1010, 4'b0110, 4'b0010, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[9]  = {4'b1010, 4'b1010, 4'b0110, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[10] = {4'b1010, 4'b1010, 4'b0110, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[11] = {4'b0000, 4'b1010, 4'b0110, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0};
        tbl[12] = {4'b0000, 4'b1010, 4'b0110, 4'b0000, 1'b1, 2'd1, 1'b0, 1'b1};
        tbl[13] = {4'b0000, 4'b1010, 4'b0110, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1};

        // reset holds grants off even with every request up
        req = 4'b1111;
        @(posedge clk);
        #4;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;
        #3 chk("rst_first_gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;

        do_reset();
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            a   = tbl[i].a;
            b   = tbl[i].b;
            #4;
            chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid), 32'(tbl[i].v));
            chk($sformatf("rsp_id[%0d]", i), 32'(rsp_id), 32'(tbl[i].id));
            chk($sformatf("rsp_sum[%0d]", i), 32'(rsp_sum), 32'(tbl[i].s));
            chk($sformatf("rsp_carry[%0d]", i), 32'(rsp_carry), 32'(tbl[i].c));
            @(posedge clk);
            #1;
        end

        // LAT=3: issue ids 0 and 1, then reset while both are in flight
        do_reset();
        req3 = 4'b0011; a3 = 4'b0011; b3 = 4'b0001;
        #3 chk("l3_gnt0", 32'(gnt3), 32'b0001);
        @(posedge clk);
        #1 req3 = 4'b0010;
        #3 chk("l3_gnt1", 32'(gnt3), 32'b0010);
        @(posedge clk);
        #1 req3 = 4'b0000;
        @(posedge clk);
        #1 rstn = 1'b0;
        #3 chk("l3_rst_gnt", 32'(gnt3), 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                #3 if (rsp_valid3) seen++;
                @(posedge clk);
                #1;
            end
            chk("l3_no_rsp_after_rst", 32'(seen), 32'h0);
        end
        req3 = 4'b0011;
        #3 chk("l3_gnt_after_rst", 32'(gnt3), 32'b0001);
        @(posedge clk);
        #1 req3 = 4'b0000;

`ifdef HA_SCHED_STATS_EN
        do_reset();
        req = 4'b0010;
        repeat (70000) @(posedge clk);
        #1 req = 4'b0000;
        chk("cnt1_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
        chk("cnt0", 32'(grant_cnt[15:0]), 32'h0);
        chk("cnt2", 32'(grant_cnt[47:32]), 32'h0);
        chk("cnt3", 32'(grant_cnt[63:48]), 32'h0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
